// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter family.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Modulo increment with an explicit wrap compare, so non power-of-two
  // requester counts wrap correctly from num-1 back to 0.
  function automatic int idx_inc(input int idx, input int num);
    return (idx >= num - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotated-priority picker: first set req at or after ptr, modulo NUM.
// Latency: purely combinational.
// Backpressure: none; found=0 when no requester is active.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int NUM = 3,
  parameter int IDW = $clog2(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  int w_cur;

  // Walk ptr, ptr+1, ... with wrap; the first active request wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_cur = int'(ptr);
    for (int k = 0; k < NUM; k++) begin
      if (!found && req[IDW'(w_cur)]) begin
        found = 1'b1;
        idx   = IDW'(w_cur);
      end
      w_cur = idx_inc(w_cur, NUM);
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with burst hold and optional hold limit.
// Latency: req to gnt 1 cycle; completion to gnt low 1 cycle; 1 idle cycle between grants.
// Backpressure: owner holds gnt until last, req drop or hold limit; others wait.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM      = 3,
  parameter int IDW      = $clog2(NUM),
  parameter int WEIGHT_W = 4,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM-1:0]          req,
  input  logic [NUM-1:0]          last,
  input  logic [NUM*WEIGHT_W-1:0] weight,
  output logic [NUM-1:0]          gnt,
  output logic                    gnt_valid,
  output logic [IDW-1:0]          gnt_id,
  output logic                    timeout
);

  localparam int HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_t            r_state;
  logic [IDW-1:0]        r_ptr;
  logic [WEIGHT_W-1:0]   r_credit [NUM];
  logic [HOLD_W-1:0]     r_hold;
  logic [NUM-1:0]        r_gnt;
  logic [IDW-1:0]        r_gnt_id;
  logic                  r_timeout;

  logic                  w_found;
  logic [IDW-1:0]        w_pick_idx;
  logic [WEIGHT_W-1:0]   w_pick_wt;
  logic [WEIGHT_W-1:0]   w_load_wt;
  logic [WEIGHT_W-1:0]   w_credit_dec;
  logic [IDW-1:0]        w_ptr_inc;
  logic                  w_complete;
  logic                  w_hold_hit;

  arb_rr_pick #(
    .NUM (NUM),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  // Select the weight field of the candidate winner; weight 0 means 1 burst.
  always_comb begin
    w_pick_wt = '0;
    for (int i = 0; i < NUM; i++) begin
      if (IDW'(i) == w_pick_idx) w_pick_wt = weight[i*WEIGHT_W +: WEIGHT_W];
    end
    w_load_wt = (w_pick_wt == '0) ? WEIGHT_W'(1) : w_pick_wt;
  end

  // Owner is always r_gnt_id while in GRANT; abandon counts as completion.
  assign w_complete   = ~req[r_gnt_id] | last[r_gnt_id];
  assign w_hold_hit   = (MAX_HOLD != 0) && (r_hold == HOLD_W'(HOLD_LIM));
  assign w_credit_dec = r_credit[r_gnt_id] - WEIGHT_W'(1);
  assign w_ptr_inc    = IDW'(idx_inc(int'(r_gnt_id), NUM));

  // Arbitration FSM: pick in IDLE, hold in GRANT, release on completion or hold limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_timeout <= 1'b0;
      for (int i = 0; i < NUM; i++) r_credit[i] <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state  <= ARB_GRANT;
            r_gnt    <= NUM'(1) << w_pick_idx;
            r_gnt_id <= w_pick_idx;
            r_hold   <= '0;
            // A fresh turn samples weight; a continuing turn keeps its credit.
            if (r_credit[w_pick_idx] == '0) r_credit[w_pick_idx] <= w_load_wt;
          end
        end
        ARB_GRANT: begin
          if (w_complete) begin
            r_credit[r_gnt_id] <= w_credit_dec;
            r_ptr              <= (w_credit_dec == '0) ? w_ptr_inc : r_gnt_id;
            r_gnt              <= '0;
            r_hold             <= '0;
            r_state            <= ARB_IDLE;
          end else if (w_hold_hit) begin
            // Overrun forfeits the rest of the turn.
            r_credit[r_gnt_id] <= '0;
            r_ptr              <= w_ptr_inc;
            r_timeout          <= 1'b1;
            r_gnt              <= '0;
            r_hold             <= '0;
            r_state            <= ARB_IDLE;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_id    = r_gnt_id;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: main instance (hold limit 16) and a
// hold-limit-4 instance sharing the same stimulus.
module tb_wrr_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  last;
  logic [11:0] weight;

  logic [2:0]  gnt,  gnt4;
  logic        gnt_valid, gnt_valid4;
  logic [1:0]  gnt_id, gnt_id4;
  logic        timeout, timeout4;

  int n_pass  = 0;
  int n_total = 0;

  wrr_arbiter #(.NUM(3), .WEIGHT_W(4), .MAX_HOLD(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .weight(weight),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout)
  );

  wrr_arbiter #(.NUM(3), .WEIGHT_W(4), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .last(last), .weight(weight),
    .gnt(gnt4), .gnt_valid(gnt_valid4), .gnt_id(gnt_id4), .timeout(timeout4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; last = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 3'b111; last = 3'b000; weight = 12'h111;
    tick(); tick();
    n_total++; if (gnt !== 3'b000) $display("FAIL reset_gnt got=%b exp=000", gnt); else n_pass++;
    n_total++; if (gnt_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", gnt_valid); else n_pass++;
    n_total++; if (gnt_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", gnt_id); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else n_pass++;
    n_total++; if (gnt4 !== 3'b000) $display("FAIL reset_gnt4 got=%b exp=000", gnt4); else n_pass++;
    rst = 1'b0; last = 3'b111;
    tick();
    n_total++; if (gnt !== 3'b001) $display("FAIL reset_first_grant got=%b exp=001", gnt); else n_pass++;
  endtask

  task automatic test_rotation;
    logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [2:0] exp_gnt;
    do_reset();
    weight = 12'h111; req = 3'b111; last = 3'b111;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k % 2 == 0) begin
        exp_gnt = 3'b001 << seq[k/2];
        n_total++; if (gnt !== exp_gnt) $display("FAIL rot_gnt k=%0d got=%b exp=%b", k, gnt, exp_gnt); else n_pass++;
        n_total++; if (gnt_id !== seq[k/2]) $display("FAIL rot_id k=%0d got=%0d exp=%0d", k, gnt_id, seq[k/2]); else n_pass++;
      end else begin
        n_total++; if (gnt_valid !== 1'b0) $display("FAIL rot_idle k=%0d got=%b exp=0", k, gnt_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_weighting;
    logic [1:0] seq [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    do_reset();
    weight = 12'h113; req = 3'b111; last = 3'b111;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k % 2 == 0) begin
        n_total++; if (gnt_id !== seq[k/2] || gnt_valid !== 1'b1)
          $display("FAIL wt_id k=%0d got=%0d/%b exp=%0d/1", k, gnt_id, gnt_valid, seq[k/2]); else n_pass++;
      end
    end
  endtask

  task automatic test_zero_weight;
    logic [1:0] seq [3] = '{2'd0, 2'd1, 2'd2};
    do_reset();
    weight = 12'h000; req = 3'b111; last = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) begin
        n_total++; if (gnt_id !== seq[k/2] || gnt_valid !== 1'b1)
          $display("FAIL zw_id k=%0d got=%0d/%b exp=%0d/1", k, gnt_id, gnt_valid, seq[k/2]); else n_pass++;
      end
    end
  endtask

  task automatic test_burst_hold;
    do_reset();
    weight = 12'h111; req = 3'b111; last = 3'b001;
    tick();
    n_total++; if (gnt !== 3'b001) $display("FAIL bh_pre got=%b exp=001", gnt); else n_pass++;
    tick();
    last = 3'b000;
    tick();
    n_total++; if (gnt !== 3'b010) $display("FAIL bh_beat1 got=%b exp=010", gnt); else n_pass++;
    for (int b = 2; b <= 5; b++) begin
      tick();
      n_total++; if (gnt !== 3'b010) $display("FAIL bh_beat%0d got=%b exp=010", b, gnt); else n_pass++;
    end
    last = 3'b010;
    tick();
    n_total++; if (gnt !== 3'b000) $display("FAIL bh_release got=%b exp=000", gnt); else n_pass++;
    last = 3'b000;
    tick();
    n_total++; if (gnt !== 3'b100 || gnt_id !== 2'd2) $display("FAIL bh_next got=%b/%0d exp=100/2", gnt, gnt_id); else n_pass++;
  endtask

  task automatic test_timeout;
    do_reset();
    weight = 12'h111; req = 3'b011; last = 3'b000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_total++; if (gnt4 !== 3'b001 || timeout4 !== 1'b0)
        $display("FAIL to_hold c=%0d got=%b/%b exp=001/0", c, gnt4, timeout4); else n_pass++;
    end
    tick();
    n_total++; if (gnt4 !== 3'b000 || timeout4 !== 1'b1) $display("FAIL to_pulse got=%b/%b exp=000/1", gnt4, timeout4); else n_pass++;
    n_total++; if (gnt !== 3'b001 || timeout !== 1'b0) $display("FAIL to_long_limit got=%b/%b exp=001/0", gnt, timeout); else n_pass++;
    tick();
    n_total++; if (gnt4 !== 3'b010 || timeout4 !== 1'b0) $display("FAIL to_next got=%b/%b exp=010/0", gnt4, timeout4); else n_pass++;
  endtask

  task automatic test_limit_tie;
    do_reset();
    weight = 12'h111; req = 3'b001; last = 3'b000;
    tick(); tick(); tick(); tick();
    n_total++; if (gnt4 !== 3'b001) $display("FAIL tie_hold got=%b exp=001", gnt4); else n_pass++;
    last = 3'b001;
    tick();
    n_total++; if (gnt4 !== 3'b000 || timeout4 !== 1'b0) $display("FAIL tie_release got=%b/%b exp=000/0", gnt4, timeout4); else n_pass++;
    req = 3'b011; last = 3'b000;
    tick();
    n_total++; if (gnt4 !== 3'b010) $display("FAIL tie_next got=%b exp=010", gnt4); else n_pass++;
  endtask

  task automatic test_abandon_wrap;
    do_reset();
    weight = 12'h111; req = 3'b100; last = 3'b000;
    tick();
    n_total++; if (gnt_id !== 2'd2 || gnt !== 3'b100) $display("FAIL ab_grant got=%b/%0d exp=100/2", gnt, gnt_id); else n_pass++;
    tick();
    n_total++; if (gnt !== 3'b100) $display("FAIL ab_hold got=%b exp=100", gnt); else n_pass++;
    req = 3'b011;
    tick();
    n_total++; if (gnt !== 3'b000 || timeout !== 1'b0) $display("FAIL ab_release got=%b/%b exp=000/0", gnt, timeout); else n_pass++;
    n_total++; if (gnt_id !== 2'd2) $display("FAIL ab_id_hold got=%0d exp=2", gnt_id); else n_pass++;
    tick();
    n_total++; if (gnt !== 3'b001 || gnt_id !== 2'd0) $display("FAIL ab_wrap got=%b/%0d exp=001/0", gnt, gnt_id); else n_pass++;
  endtask

  task automatic test_mid_reset;
    do_reset();
    weight = 12'h111; req = 3'b011; last = 3'b001;
    tick(); tick();
    last = 3'b000;
    tick();
    n_total++; if (gnt !== 3'b010) $display("FAIL mr_owner got=%b exp=010", gnt); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_total++; if (gnt !== 3'b000 || gnt_valid !== 1'b0) $display("FAIL mr_gnt got=%b/%b exp=000/0", gnt, gnt_valid); else n_pass++;
    n_total++; if (gnt_id !== 2'd0 || timeout !== 1'b0) $display("FAIL mr_id_to got=%0d/%b exp=0/0", gnt_id, timeout); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (gnt !== 3'b001 || gnt_id !== 2'd0) $display("FAIL mr_restart got=%b/%0d exp=001/0", gnt, gnt_id); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; weight = '0;
    test_reset();
    test_rotation();
    test_weighting();
    test_zero_weight();
    test_burst_hold();
    test_timeout();
    test_limit_tie();
    test_abandon_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
